// File: rtl/stream_ser_pkg.sv
// Shared types and helpers for the wide-word to byte-stream serializer.
//   BYTE_W / WORD_W     : default byte and word widths
//   CNT_W               : width of the per-word valid byte count
//   ser_state_t         : serializer FSM states
//   norm_bytes()        : maps an out-of-range byte count (0 or > bytes/word) to a full word
package stream_ser_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 64;
    localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;
    localparam int unsigned CNT_W          = 4;

    typedef enum logic [0:0] {
        IDLE,
        SEND
    } ser_state_t;

    function automatic logic [CNT_W-1:0] norm_bytes(input logic [CNT_W-1:0] b);
        if (b == '0 || 32'(b) > BYTES_PER_WORD) begin
            return CNT_W'(BYTES_PER_WORD);
        end
        return b;
    endfunction

endpackage

// File: rtl/stream_wide_serializer_if.sv
// Byte-stream ready/valid bus between the serializer and the byte-stream consumer.
//   valid : byte valid (master -> slave)
//   ready : consumer ready (slave -> master)
//   data  : byte payload
//   last  : final byte of a word
// Modports: master (serializer side), slave (consumer side).
interface stream_wide_serializer_if #(
    parameter int unsigned BYTE_W = 8
) ();

    logic              valid;
    logic              ready;
    logic [BYTE_W-1:0] data;
    logic              last;

    modport master (
        output valid,
        output data,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  last,
        output ready
    );

endinterface

// File: rtl/stream_skid_buffer.sv
// Two-entry FIFO used as a skid buffer in front of the serializer core.
// in_ready is a register, so upstream never sees a combinational path from out_ready.
//   clk, reset_n            : clock, synchronous active-low reset
//   in_valid/in_ready/in_data    : write side
//   out_valid/out_ready/out_data : read side (out_data is the head entry)
module stream_skid_buffer #(
    parameter int unsigned DATA_W = stream_ser_pkg::WORD_W + 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic              in_ready_q;
    logic              push;
    logic              pop;

    assign push      = in_valid && in_ready_q;
    assign pop       = out_valid && out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q    <= count_d;
            // Ready for the next cycle reflects the occupancy after this edge.
            in_ready_q <= (count_d != 2'd2);
        end
    end

    // Storage needs no reset; entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: rtl/stream_wide_serializer.sv
// Serializes WORD_W-bit words carrying 1..8 valid bytes into a byte stream, one byte per
// handshake, flagging the final byte of each word with last.
//   clk, reset_n : clock, synchronous active-low reset
//   word_valid/word_ready/word_data/word_bytes : upstream word side (word_ready registered)
//   stream_in    : byte-stream master (valid/ready/data/last)
//   busy         : a word is buffered or being sent
// Build option: define STREAM_SER_MSB_FIRST_EN to emit the most significant valid byte first.
module stream_wide_serializer #(
    parameter int unsigned WORD_W = stream_ser_pkg::WORD_W,
    parameter int unsigned BYTE_W = stream_ser_pkg::BYTE_W
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        word_valid,
    output logic                        word_ready,
    input  logic [WORD_W-1:0]           word_data,
    input  logic [3:0]                  word_bytes,
    stream_wide_serializer_if.master    stream_in,
    output logic                        busy
);

    import stream_ser_pkg::*;

    localparam int unsigned NUM_BYTES = WORD_W / BYTE_W;
    localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int unsigned BUF_W     = WORD_W + CNT_W;

    logic              buf_out_valid;
    logic              buf_pop;
    logic [BUF_W-1:0]  buf_in_data;
    logic [BUF_W-1:0]  buf_out_data;
    logic [WORD_W-1:0] head_data;
    logic [CNT_W-1:0]  head_cnt;

    ser_state_t        state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              out_valid;
    logic              is_last;
    logic [IDX_W-1:0]  sel;
    logic [BYTE_W-1:0] sel_byte;

    // The count is normalised on entry so the core never sees 0 or an oversize count.
    assign buf_in_data = {word_data, norm_bytes(word_bytes)};
    assign head_data   = buf_out_data[BUF_W-1 -: WORD_W];
    assign head_cnt    = buf_out_data[CNT_W-1:0];

    stream_skid_buffer #(
        .DATA_W (BUF_W)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (word_valid),
        .in_ready  (word_ready),
        .in_data   (buf_in_data),
        .out_valid (buf_out_valid),
        .out_ready (buf_pop),
        .out_data  (buf_out_data)
    );

    assign is_last = (CNT_W'(idx_q) == cnt_q - CNT_W'(1));

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        buf_pop   = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (buf_out_valid) begin
                    buf_pop = 1'b1;
                    shift_d = head_data;
                    idx_d   = '0;
                    cnt_d   = head_cnt;
                    state_d = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                if (stream_in.ready) begin
                    if (!is_last) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (buf_out_valid) begin
                        // Reload on the last byte so consecutive words have no bubble.
                        buf_pop = 1'b1;
                        shift_d = head_data;
                        idx_d   = '0;
                        cnt_d   = head_cnt;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
`ifdef STREAM_SER_MSB_FIRST_EN
        // Valid bytes are the low cnt bytes; walk them from the top down.
        sel = IDX_W'(cnt_q - CNT_W'(1) - CNT_W'(idx_q));
`else
        sel = idx_q;
`endif
        sel_byte = '0;
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            if (32'(sel) == i) begin
                sel_byte = shift_q[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign stream_in.valid = out_valid;
    assign stream_in.data  = out_valid ? sel_byte : '0;
    assign stream_in.last  = out_valid && is_last;
    assign busy            = (state_q != IDLE) || buf_out_valid;

endmodule

// File: doc/stream_wide_serializer.md
Name: stream_wide_serializer

Overview:
- Upstream feeder for the byte-stream consumer. Accepts 64-bit words with a valid byte count and emits them one byte per handshake on the 8-bit `stream_in_*` ready/valid interface.
- Marks the final byte of each word with `stream_in_last`.
- A 2-entry skid buffer on the word side keeps `word_ready` registered, so there is no combinational ready path from downstream to upstream.

Parameters:
- WORD_W, 64, input word width; must be a multiple of BYTE_W.
- BYTE_W, 8, output data width.
- BYTES_PER_WORD, WORD_W/BYTE_W (8), derived; not to be overridden.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- word_valid  input  1  upstream word valid.
- word_ready  output  1  upstream word ready (registered).
- word_data  input  64  word payload; byte 0 = bits [7:0].
- word_bytes  input  4  number of valid bytes, 1..8; 0 or >8 is treated as 8.
- stream_in_valid  output  1  byte valid to the downstream consumer.
- stream_in_ready  input  1  downstream ready.
- stream_in_data  output  8  byte payload.
- stream_in_last  output  1  high on the last byte of a word.
- busy  output  1  high while any word is buffered or being sent.

Behaviour:
- Reset (reset_n low at a clk edge):
  - Outputs: word_ready=0, stream_in_valid=0, stream_in_data=0, stream_in_last=0, busy=0.
  - Skid buffer is emptied and the FSM goes to IDLE.
  - word_ready rises on the first edge after reset_n goes high.
- Handshakes:
  - Word transfer when word_valid && word_ready at a clk edge.
  - Byte transfer when stream_in_valid && stream_in_ready.
  - Once stream_in_valid is asserted, it and stream_in_data/stream_in_last hold until the byte transfers.
- Skid buffer:
  - word_ready = !(entry count == 2), computed from registered state only.
  - Buffered entries hold {data, byte count}; the normalised byte count is stored.
- FSM, two states:
  - IDLE: when the buffer is non-empty, pop the head into the shift register, set idx=0 and cnt=stored count, and go to SEND.
  - SEND:
    - stream_in_valid=1; stream_in_data = byte idx of the shift register; stream_in_last = (idx == cnt-1).
    - On a byte transfer with !last: idx+1.
    - On a byte transfer with last: pop the next word in the same cycle if the buffer is non-empty (stay in SEND, idx=0); otherwise go to IDLE.
- Latency and throughput:
  - A word accepted into an empty block at edge N gives its first byte valid after edge N+1.
  - Back-to-back words stream with no bubble between the last byte of one word and the first byte of the next.
  - Sustained throughput is 1 byte/cycle.
- Simultaneous push and pop on the skid buffer: count unchanged; ordering is FIFO.
- Full buffer: word_ready=0 until a pop occurs; word_ready returns high the following cycle.
- word_bytes=1: a single byte is sent with last=1.
- Downstream stall (stream_in_ready=0) at any point: all outputs stay stable with no loss; the buffer may fill to 2.
- Reset mid-word: the partial word is discarded; no further bytes are emitted after reset.
- busy = (FSM != IDLE) || (buffer count != 0).

Optional Feature:
- Macro: STREAM_SER_MSB_FIRST_EN.
- Defined: bytes are emitted most-significant valid byte first. With count c, the byte order is c-1 down to 0, so the valid bytes are always the low c bytes of word_data.
- Undefined (default): LSB first, byte order 0 up to c-1.
- last/handshake timing is identical in both builds.

Decomposition:
- Package `stream_ser_pkg`:
  - BYTE_W and WORD_W localparams.
  - `ser_state_t` enum {IDLE, SEND}.
  - Function `norm_bytes` mapping 0 or >8 to 8.
- Sub-module `stream_skid_buffer`:
  - Parameter DATA_W = WORD_W+4.
  - 2-entry FIFO with registered in_ready, out_valid/out_ready, and synchronous active-low reset.
- The serializer core (FSM, index counter, byte mux) stays in `stream_wide_serializer`.

Test Plan:
- Single word: word_data=64'h0807060504030201, bytes=8, ready held 1 -> bytes 01..08 on consecutive cycles, first one cycle after accept, last=1 only on 08.
- Partial word: bytes=3, data=...CCBBAA -> AA,BB,CC with last on CC. With STREAM_SER_MSB_FIRST_EN: CC,BB,AA with last on AA.
- Back-to-back: 3 full words with word_valid held and stream_in_ready=1 -> 24 bytes in 24 consecutive cycles, last on bytes 8/16/24. word_ready never drops below the rate needed.
- Backpressure: stream_in_ready=0 for 20 cycles mid-word while upstream offers 3 words -> word_ready=0 after 2 are buffered, outputs stable, and all bytes arrive in order after release.
- Boundary counts: bytes=0 and bytes=9 -> 8 bytes each; bytes=1 -> one byte with last=1.
- Reset mid-word: assert reset_n=0 after byte 3 of 8 -> next cycle stream_in_valid=0 and busy=0; after release a new word emits from byte 0 with no stale data.
